// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data access.
// Round-robin on ties, req/ack handshake with busy timeout, sticky error flag.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              dm_read,
    input  logic              dm_write,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall,
    output logic              err
);

    // Counter only needs to reach TIMEOUT-1: the last busy cycle is the one that aborts.
    localparam int unsigned     CntW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StBusyIf, StBusyDm, StResp} state_e;

    state_e            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              if_done_q, if_done_d;
    logic              dm_done_q, dm_done_d;
    logic              err_q, err_d;
    logic              last_dm_q, last_dm_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              dm_any;
    logic              timeout;

    assign dm_any = dm_read | dm_write;

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_done_d   = 1'b0;
        dm_done_d   = 1'b0;
        err_d       = err_q;
        last_dm_d   = last_dm_q;
        cnt_d       = cnt_q;
        timeout     = 1'b0;

        unique case (state_q)
            StIdle: begin
                // DM wins unless IF also waits and DM had the previous grant.
                if (dm_any && (!if_req || !last_dm_q)) begin
                    state_d     = StBusyDm;
                    last_dm_d   = 1'b1;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_write;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    if (dm_read && dm_write) begin
                        err_d = 1'b1;
                    end
                end else if (if_req) begin
                    state_d    = StBusyIf;
                    last_dm_d  = 1'b0;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = if_addr;
                end
            end
            StBusyIf, StBusyDm: begin
                timeout = !mem_ack && (cnt_q == CntLast);
                if (mem_ack || timeout) begin
                    state_d   = StResp;
                    mem_req_d = 1'b0;
                    if_done_d = (state_q == StBusyIf);
                    dm_done_d = (state_q == StBusyDm);
                    if (timeout) begin
                        err_d = 1'b1;
                    end
                    if (state_q == StBusyIf) begin
                        if_rdata_d = mem_ack ? mem_rdata : '1;
                    end else if (!mem_we_q) begin
                        dm_rdata_d = mem_ack ? mem_rdata : '1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_done_q   <= 1'b0;
            dm_done_q   <= 1'b0;
            err_q       <= 1'b0;
            last_dm_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_done_q   <= if_done_d;
            dm_done_q   <= dm_done_d;
            err_q       <= err_d;
            last_dm_q   <= last_dm_d;
            cnt_q       <= cnt_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_done   = if_done_q;
    assign dm_done   = dm_done_q;
    assign err       = err_q;
    assign stall     = (if_req & ~if_done_q) | (dm_any & ~dm_done_q);

endmodule
